// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// Lines are four 32-bit words; word 0 sits in bits [31:0].
package dcache_pkg;

    localparam int OFFSET_W       = 4;
    localparam int WORDS_PER_LINE = 4;

    typedef logic [127:0] line_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL
    } dcache_state_e;

endpackage

// File: rtl/dcache_line_store.sv
// Data, tag, valid and dirty arrays for the cache: one combinational read port,
// one write port (single word or whole line). Only valid/dirty are cleared by reset.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int TAG_W     = 8,
    localparam int INDEX_W  = $clog2(NUM_LINES)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INDEX_W-1:0] i_rd_index,
    output line_t              o_rd_line,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic               o_rd_valid,
    output logic               o_rd_dirty,
    input  logic               i_wr_word_en,
    input  logic               i_wr_line_en,
    input  logic               i_clr_dirty,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [1:0]         i_wr_offset,
    input  word_t              i_wr_word,
    input  line_t              i_wr_line,
    input  logic [TAG_W-1:0]   i_wr_tag
);

    line_t                r_data [NUM_LINES];
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    always_ff @(posedge clock) begin
        if (i_wr_line_en) begin
            r_data[i_wr_index] <= i_wr_line;
            r_tag[i_wr_index]  <= i_wr_tag;
        end else if (i_wr_word_en) begin
            r_data[i_wr_index][{i_wr_offset, 5'd0} +: 32] <= i_wr_word;
        end
    end

    // A refilled line arrives clean; a word store marks it dirty.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_wr_line_en) begin
            r_valid[i_wr_index] <= 1'b1;
            r_dirty[i_wr_index] <= 1'b0;
        end else if (i_wr_word_en) begin
            r_dirty[i_wr_index] <= 1'b1;
        end else if (i_clr_dirty) begin
            r_dirty[i_wr_index] <= 1'b0;
        end
    end

    assign o_rd_line  = r_data[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_dirty = r_dirty[i_rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: request latch,
// lookup/writeback/refill FSM and hit/miss counters in front of a line-wide memory.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int ADDR_W    = 14,
    parameter int LINE_W    = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-5:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;

    dcache_state_e       r_state;
    logic                r_req_ready;
    logic                r_we;
    logic [ADDR_W-1:2]   r_addr;
    word_t               r_wdata;
    logic                r_after_refill;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-5:0]   r_mem_addr;
    line_t               r_mem_wdata;
    logic [31:0]         r_hit_count;
    logic [31:0]         r_miss_count;

    logic [1:0]          w_offset;
    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    line_t               w_rd_line;
    logic [TAG_W-1:0]    w_rd_tag;
    logic                w_rd_valid;
    logic                w_rd_dirty;
    logic                w_hit;
    word_t               w_word;
    logic                w_unused;

    assign w_unused = ^{req_addr[31:ADDR_W], req_addr[1:0]};

    assign w_offset = r_addr[3:2];
    assign w_index  = r_addr[INDEX_W+3:4];
    assign w_tag    = r_addr[ADDR_W-1:INDEX_W+4];
    assign w_hit    = w_rd_valid && (w_rd_tag == w_tag);
    assign w_word   = w_rd_line[{w_offset, 5'd0} +: 32];

    dcache_line_store #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W)
    ) u_store (
        .clock        (clock),
        .reset        (reset),
        .i_rd_index   (w_index),
        .o_rd_line    (w_rd_line),
        .o_rd_tag     (w_rd_tag),
        .o_rd_valid   (w_rd_valid),
        .o_rd_dirty   (w_rd_dirty),
        .i_wr_word_en (resp_valid && r_we),
        .i_wr_line_en ((r_state == REFILL) && mem_ready),
        .i_clr_dirty  ((r_state == WRITEBACK) && mem_ready),
        .i_wr_index   (w_index),
        .i_wr_offset  (w_offset),
        .i_wr_word    (r_wdata),
        .i_wr_line    (mem_rdata),
        .i_wr_tag     (w_tag)
    );

    // The response is produced in the LOOKUP cycle itself, so it is decoded from state.
    assign resp_valid = (r_state == LOOKUP) && w_hit;
    assign resp_rdata = resp_valid ? (r_we ? r_wdata : w_word) : 32'd0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_req_ready    <= 1'b1;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_after_refill <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_hit_count    <= '0;
            r_miss_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we           <= req_we;
                        r_addr         <= req_addr[ADDR_W-1:2];
                        r_wdata        <= req_wdata;
                        r_after_refill <= 1'b0;
                        r_req_ready    <= 1'b0;
                        r_state        <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        if (!r_after_refill) begin
                            r_hit_count <= r_hit_count + 32'd1;
                        end
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else if (w_rd_valid && w_rd_dirty) begin
                        r_miss_count <= r_miss_count + 32'd1;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= {w_rd_tag, w_index};
                        r_mem_wdata  <= w_rd_line;
                        r_state      <= WRITEBACK;
                    end else begin
                        r_miss_count <= r_miss_count + 32'd1;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= {w_tag, w_index};
                        r_state      <= REFILL;
                    end
                end
                WRITEBACK: begin
                    // The refill request follows back-to-back; victim data stays on mem_wdata.
                    if (mem_ready) begin
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {w_tag, w_index};
                        r_state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        r_mem_req      <= 1'b0;
                        r_after_refill <= 1'b1;
                        r_state        <= LOOKUP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
